// File: rtl/priority_encoder_scan.sv
// Serialises the set bits of one WIDTH-bit word into one beat per cycle, MSB- or LSB-first.
// Latency: beat 0 one cycle after accept; backpressure holds the current beat and the residue unchanged.
module priority_encoder_scan #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             msb_first_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic             val_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             zero_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   residue_q, residue_d;
    logic               order_q, order_d;

    logic               rdy_d;
    logic               val_d;
    logic [WIDTH-1:0]   onehot_d;
    logic [IDX_W-1:0]   index_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               last_d;
    logic               zero_d;

    // Shared picker: fresh input word in IDLE, residue minus the emitted bit in SCAN.
    logic [WIDTH-1:0]   sel_word;
    logic               sel_msb;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   pick_oh;
    logic               pick_single;

    always_comb begin
        sel_word = (state_q == IDLE) ? data_i : (residue_q & ~onehot_o);
        sel_msb  = (state_q == IDLE) ? msb_first_i : order_q;
        pick_idx = '0;
        if (sel_msb) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sel_word[i]) pick_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (sel_word[i]) pick_idx = IDX_W'(i);
            end
        end
        pick_oh     = (sel_word != '0) ? (WIDTH'(1) << pick_idx) : '0;
        pick_single = (sel_word != '0) && ((sel_word & (sel_word - WIDTH'(1))) == '0);
    end

    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        order_d   = order_q;
        rdy_d     = data_ready_o;
        val_d     = val_o;
        onehot_d  = onehot_o;
        index_d   = index_o;
        cnt_d     = cnt_o;
        last_d    = last_o;
        zero_d    = zero_o;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                val_d = 1'b0;
                if (data_val_i && data_ready_o) begin
                    state_d   = SCAN;
                    residue_d = data_i;
                    order_d   = msb_first_i;
                    rdy_d     = 1'b0;
                    val_d     = 1'b1;
                    onehot_d  = pick_oh;
                    index_d   = pick_idx;
                    cnt_d     = '0;
                    zero_d    = (data_i == '0);
                    last_d    = (data_i == '0) || pick_single;
                end
            end
            SCAN: begin
                if (ready_i) begin
                    if (last_o) begin
                        state_d   = IDLE;
                        residue_d = '0;
                        rdy_d     = 1'b1;
                        val_d     = 1'b0;
                        onehot_d  = '0;
                        index_d   = '0;
                        cnt_d     = '0;
                        last_d    = 1'b0;
                        zero_d    = 1'b0;
                    end else begin
                        residue_d = sel_word;
                        onehot_d  = pick_oh;
                        index_d   = pick_idx;
                        cnt_d     = cnt_o + CNT_W'(1);
                        last_d    = pick_single;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= IDLE;
            residue_q    <= '0;
            order_q      <= 1'b0;
            data_ready_o <= 1'b0;
            val_o        <= 1'b0;
            onehot_o     <= '0;
            index_o      <= '0;
            cnt_o        <= '0;
            last_o       <= 1'b0;
            zero_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            residue_q    <= residue_d;
            order_q      <= order_d;
            data_ready_o <= rdy_d;
            val_o        <= val_d;
            onehot_o     <= onehot_d;
            index_o      <= index_d;
            cnt_o        <= cnt_d;
            last_o       <= last_d;
            zero_o       <= zero_d;
        end
    end

endmodule
